prf_rx_gate: RTL
================

# prf_rx_gate

Receive-side companion to the PRF generator. Samples the `prf` strobe in the `fclk` domain and detects its falling edge (end of transmit pulse). After a programmable blanking interval it opens a fixed-length receive range gate with a per-sample range-bin index. It also measures the PRF period and flags out-of-tolerance or aborted sweeps for the downstream beamformer capture logic.

## Interface
- `BLANK_CYCLES`, 20: cycles between `rx_start` and the first gated sample (≥1).
- `WINDOW_LEN`, 1000: gated samples per sweep (≥1).
- `PRI_NOM`, 1150: nominal PRF period in `fclk` cycles.
- `PRI_TOL`, 4: allowed |measured − `PRI_NOM`| in cycles.
- `CNT_W`, 16: width of all counters and of the `range_bin` / `pri_count` outputs.

Ports:
- `fclk`  in  1: the single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: run control. Low forces IDLE.
- `prf`  in  1: PRF strobe, synchronous to `fclk`. High means transmit.
- `rx_start`  out  1: one-cycle pulse marking the end of transmit.
- `rx_gate`  out  1: high while the receive window is open.
- `range_bin`  out  CNT_W: sample index inside the window, 0..`WINDOW_LEN`−1. 0 when the gate is closed.
- `pri_count`  out  CNT_W: last measured rise-to-rise period.
- `pri_valid`  out  1: one-cycle pulse when `pri_count` updates.
- `pri_err`  out  1: qualifies `pri_valid`. Set when the period is out of tolerance.
- `gate_abort`  out  1: one-cycle pulse when a sweep is cut short.

## Operation
- `prf_q` registers `prf` each cycle.
  - rise = `prf & ~prf_q`
  - fall = `~prf & prf_q`
- `prf_q` only updates while `enable` = 1. In IDLE it is cleared, so if `prf` is high at enable, a rise is seen.
- FSM states:
  - IDLE: entered on `rst` or `enable` = 0. Goes to WAIT_FALL on rise.
  - WAIT_FALL: goes to BLANK on fall. Registers `rx_start` = 1 for the next cycle and loads the blank counter.
  - BLANK: counts `BLANK_CYCLES` cycles, with the `rx_start` cycle as count 1. Then goes to GATE.
  - GATE: `rx_gate` = 1 and `range_bin` increments 0..`WINDOW_LEN`−1, one per cycle. After the last bin, goes to HOLD.
  - HOLD: waits for rise, then goes to WAIT_FALL.
- A rise during BLANK or GATE does three things:
  - pulses `gate_abort`;
  - closes the gate;
  - goes to WAIT_FALL. The new sweep is honoured.
- A fall while in HOLD or IDLE is ignored.
- PRI counter:
  - Counts cycles while `enable` = 1.
  - On each rise it captures the count into `pri_count`, pulses `pri_valid`, and restarts at 1.
  - The first rise after reset or enable produces no `pri_valid`.
  - It saturates at 2^CNT_W − 1. A capture of the saturated value always sets `pri_err`.
- `pri_err` = (count > `PRI_NOM` + `PRI_TOL`) or (count < `PRI_NOM` − `PRI_TOL`). Compare unsigned, widened by 1 bit so `PRI_NOM` − `PRI_TOL` cannot wrap.
- `rst` or `enable` = 0, applied mid-sweep:
  - next cycle all outputs are 0 and the FSM is in IDLE;
  - `gate_abort` is not pulsed;
  - `pri_count` clears to 0.

## Timing
- Reset values: all outputs 0 and FSM = IDLE.
- Let edge F be the first `fclk` edge that samples `prf` = 0 after `prf` = 1.
  - `rx_start` is high for exactly the cycle after F.
  - `rx_gate` rises `BLANK_CYCLES` cycles after `rx_start` rises.
  - `rx_gate` stays high exactly `WINDOW_LEN` cycles.
- `range_bin` and `rx_gate` change on the same edge. `range_bin` returns to 0 on the edge where `rx_gate` falls.
- Let edge R be the edge that samples a rise. `pri_valid`, `pri_err` and `pri_count` update on R+1.
- `gate_abort` is asserted on R+1, and `rx_gate` is 0 on that same cycle.
- Fall and abort cannot coincide: a rise takes priority in the cycle it is seen.
- With the generator defaults the timing fits: 100-cycle pulse, 1150-cycle period, gate closes 1020 cycles after `rx_start`, before the next rise at 1050.

## Test plan
- Nominal: defaults, `prf` driven 100 cycles high / 1050 low for 5 periods.
  - `rx_start` is 1 cycle.
  - `rx_gate` rises 20 cycles later and lasts 1000 cycles; `range_bin` runs 0→999.
  - From the second rise on: `pri_valid` with `pri_count` = 1150 and `pri_err` = 0.
  - `gate_abort` never fires.
- Tolerance edges:
  - period 1154 → `pri_err` = 0;
  - period 1155 → `pri_err` = 1;
  - period 1145 → `pri_err` = 1;
  - period 1146 → `pri_err` = 0.
- Early PRF: rise 500 cycles after a fall, during GATE at bin 479.
  - `gate_abort` pulses 1 cycle and `rx_gate` drops on R+1.
  - The next fall starts a full 1000-bin window.
  - `pri_count` = 600, `pri_err` = 1.
- Mid-sweep reset: `rst` for 1 cycle at `range_bin` = 300.
  - Next cycle all outputs are 0 and `gate_abort` = 0.
  - The following rise gives no `pri_valid`.
  - The following fall restarts normally.
- `enable` low for 50 cycles during BLANK: outputs 0, no `rx_start`, no `gate_abort`. Re-enable mid-pulse (`prf` high): a rise is detected and the sweep starts at the next fall.
- `prf` held low for 70000 cycles, then a rise: `pri_count` = 65535, `pri_err` = 1, and no second `rx_start` until the next fall.

Source files
------------

// File: rtl/prf_rx_gate.sv
// prf_rx_gate: PRF falling-edge detect, blanked receive range gate and PRI period monitor
module prf_rx_gate #(
    parameter int BLANK_CYCLES = 20,
    parameter int WINDOW_LEN   = 1000,
    parameter int PRI_NOM      = 1150,
    parameter int PRI_TOL      = 4,
    parameter int CNT_W        = 16
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic             enable,
    input  logic             prf,
    output logic             rx_start,
    output logic             rx_gate,
    output logic [CNT_W-1:0] range_bin,
    output logic [CNT_W-1:0] pri_count,
    output logic             pri_valid,
    output logic             pri_err,
    output logic             gate_abort
);
    typedef enum logic [2:0] {IDLE, WAIT_FALL, BLANK, GATE, HOLD} state_t;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] BLANK_N  = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W:0]   PRI_HI   = (CNT_W + 1)'(PRI_NOM + PRI_TOL);
    localparam logic [CNT_W:0]   PRI_LO   = (CNT_W + 1)'((PRI_NOM > PRI_TOL) ? PRI_NOM - PRI_TOL : 0);
    state_t           state_q, state_d;
    logic             prf_q, prf_d;
    logic             rx_start_q, rx_start_d;
    logic             rx_gate_q, rx_gate_d;
    logic [CNT_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] blank_q, blank_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pri_count_q, pri_count_d;
    logic             pri_valid_q, pri_valid_d;
    logic             pri_err_q, pri_err_d;
    logic             seen_q, seen_d;
    logic             rise, fall, out_tol;

    assign rise       = prf & ~prf_q;
    assign fall       = ~prf & prf_q;
    assign out_tol    = ({1'b0, cnt_q} > PRI_HI) || ({1'b0, cnt_q} < PRI_LO);
    assign rx_start   = rx_start_q;
    assign rx_gate    = rx_gate_q;
    assign range_bin  = bin_q;
    assign pri_count  = pri_count_q;
    assign pri_valid  = pri_valid_q;
    assign pri_err    = pri_err_q;
    assign gate_abort = abort_q;

    // Next state: sweep sequencing, period capture, and a disable that wipes everything
    always_comb begin
        state_d     = state_q;
        prf_d       = prf;
        rx_start_d  = 1'b0;
        rx_gate_d   = rx_gate_q;
        bin_d       = bin_q;
        blank_d     = blank_q;
        abort_d     = 1'b0;
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
        pri_count_d = pri_count_q;
        pri_valid_d = 1'b0;
        pri_err_d   = 1'b0;
        seen_d      = seen_q;
        if (rise) begin
            cnt_d       = ONE;
            seen_d      = 1'b1;
            pri_valid_d = seen_q;
            pri_err_d   = seen_q & out_tol;
            pri_count_d = seen_q ? cnt_q : pri_count_q;
        end
        case (state_q)
            IDLE, HOLD: state_d = rise ? WAIT_FALL : state_q;
            WAIT_FALL: begin
                if (fall) begin
                    state_d    = BLANK;
                    rx_start_d = 1'b1;
                    blank_d    = ONE;
                end
            end
            BLANK: begin
                if (rise) begin
                    abort_d = 1'b1;
                    state_d = WAIT_FALL;
                end else if (blank_q == BLANK_N) begin
                    state_d   = GATE;
                    rx_gate_d = 1'b1;
                    bin_d     = '0;
                end else begin
                    blank_d = blank_q + ONE;
                end
            end
            GATE: begin
                if (rise) begin
                    abort_d   = 1'b1;
                    rx_gate_d = 1'b0;
                    bin_d     = '0;
                    state_d   = WAIT_FALL;
                end else if (bin_q == LAST_BIN) begin
                    state_d   = HOLD;
                    rx_gate_d = 1'b0;
                    bin_d     = '0;
                end else begin
                    bin_d = bin_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d     = IDLE;
            prf_d       = 1'b0;
            rx_start_d  = 1'b0;
            rx_gate_d   = 1'b0;
            bin_d       = '0;
            blank_d     = '0;
            abort_d     = 1'b0;
            cnt_d       = '0;
            pri_count_d = '0;
            pri_valid_d = 1'b0;
            pri_err_d   = 1'b0;
            seen_d      = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q     <= IDLE;
            prf_q       <= 1'b0;
            rx_start_q  <= 1'b0;
            rx_gate_q   <= 1'b0;
            bin_q       <= '0;
            blank_q     <= '0;
            abort_q     <= 1'b0;
            cnt_q       <= '0;
            pri_count_q <= '0;
            pri_valid_q <= 1'b0;
            pri_err_q   <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prf_q       <= prf_d;
            rx_start_q  <= rx_start_d;
            rx_gate_q   <= rx_gate_d;
            bin_q       <= bin_d;
            blank_q     <= blank_d;
            abort_q     <= abort_d;
            cnt_q       <= cnt_d;
            pri_count_q <= pri_count_d;
            pri_valid_q <= pri_valid_d;
            pri_err_q   <= pri_err_d;
            seen_q      <= seen_d;
        end
    end
endmodule
